// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Streams LANES-wide signed int8 activation/weight words and accumulates
//   their dot product plus the sum of all weight lanes. The weight sum
//   (row_sum_out) is consumed by the downstream requantize stage together
//   with res_out.
//
//   Ports
//     clk          single clock, rising edge
//     rst_n        asynchronous active-low reset
//     start        one-cycle request to begin a dot product (IDLE only)
//     num_words    beat count for the job, sampled with start
//     in_valid     lhs_data/rhs_data valid
//     in_ready     block accepts a beat (high only while accumulating)
//     lhs_data     LANES signed int8 activations, lane i in [8i+7:8i]
//     rhs_data     LANES signed int8 weights,     lane i in [8i+7:8i]
//     out_valid    result held valid (DONE)
//     out_ready    consumer accepts result
//     res_out      signed 32-bit accumulated sum of lhs*rhs
//     row_sum_out  signed 32-bit sum of all rhs lanes
//     busy         high whenever the block is not IDLE
//
//   Configuration macro
//     DOT_ACC_SATURATE_EN  defined: every accumulator update clamps to the
//                          signed 32-bit range; undefined: updates wrap
//                          modulo 2^32.
module dot_product_accumulator #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_words,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] lhs_data,
  input  logic [8*LANES-1:0] rhs_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        res_out,
  output logic [31:0]        row_sum_out,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Beat-sum widths carry one spare bit so the sign-extension replications
  // below never collapse to zero width (LANES == 1).
  localparam int SUM_W = 18 + $clog2(LANES);
  localparam int RS_W  = 9 + $clog2(LANES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc;
  logic [31:0]      row_sum;

  logic [16:0]      lane_a;
  logic [16:0]      lane_b;
  logic [16:0]      lane_p;
  logic [SUM_W-1:0] prod_sum;
  logic [RS_W-1:0]  rhs_sum;
  logic [31:0]      acc_next;
  logic [31:0]      row_next;
  logic             beat;

  assign in_ready    = (state == ACC);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign res_out     = acc;
  assign row_sum_out = row_sum;
  assign beat        = in_valid && (state == ACC);

  // Per-beat reduction at full precision: each lane product is an exact
  // 17-bit signed value, the lane sums are exact, and only the final add
  // into the 32-bit accumulator may overflow.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_p   = '0;
    prod_sum = '0;
    rhs_sum  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a   = {{9{lhs_data[8*i+7]}}, lhs_data[8*i +: 8]};
      lane_b   = {{9{rhs_data[8*i+7]}}, rhs_data[8*i +: 8]};
      lane_p   = lane_a * lane_b;
      prod_sum = prod_sum + {{(SUM_W-17){lane_p[16]}}, lane_p};
      rhs_sum  = rhs_sum + {{(RS_W-8){rhs_data[8*i+7]}}, rhs_data[8*i +: 8]};
    end
  end

`ifdef DOT_ACC_SATURATE_EN
  logic [33:0] acc_wide;
  logic [33:0] row_wide;

  // Two guard bits: the top three bits agree exactly when the true sum fits
  // in signed 32 bits; otherwise the guard sign picks the rail.
  always_comb begin
    acc_wide = {{2{acc[31]}}, acc} + {{(34-SUM_W){prod_sum[SUM_W-1]}}, prod_sum};
    row_wide = {{2{row_sum[31]}}, row_sum} + {{(34-RS_W){rhs_sum[RS_W-1]}}, rhs_sum};

    if ((acc_wide[33:31] == 3'b000) || (acc_wide[33:31] == 3'b111))
      acc_next = acc_wide[31:0];
    else if (acc_wide[33])
      acc_next = 32'h8000_0000;
    else
      acc_next = 32'h7FFF_FFFF;

    if ((row_wide[33:31] == 3'b000) || (row_wide[33:31] == 3'b111))
      row_next = row_wide[31:0];
    else if (row_wide[33])
      row_next = 32'h8000_0000;
    else
      row_next = 32'h7FFF_FFFF;
  end
`else
  always_comb begin
    acc_next = acc + {{(32-SUM_W){prod_sum[SUM_W-1]}}, prod_sum};
    row_next = row_sum + {{(32-RS_W){rhs_sum[RS_W-1]}}, rhs_sum};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      row_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            row_sum <= '0;
            if (num_words != '0) begin
              cnt   <= num_words;
              state <= ACC;
            end else begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc     <= acc_next;
            row_sum <= row_next;
            cnt     <= cnt - 1'b1;
            if (cnt == {{(CNT_W-1){1'b0}}, 1'b1})
              state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_words;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs_data;
  logic [31:0] rhs_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_out;
  logic [31:0] row_sum_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  logic [31:0] lq[$];
  logic [31:0] rq[$];

  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    int          exp_res;
    int          exp_row;
  } vec_t;

  dot_product_accumulator #(.LANES(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lhs_data    (lhs_data),
    .rhs_data    (rhs_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_out     (res_out),
    .row_sum_out (row_sum_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (in_valid === 1'b1 && in_ready === 1'b1) hs_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accumulator update rule: exact sum, then clamp or wrap to signed 32 bits.
  function automatic longint fold(input longint v);
`ifdef DOT_ACC_SATURATE_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    return longint'(int'(v));
`endif
  endfunction

  task automatic model(output longint er, output longint erow);
    longint a = 0;
    longint r = 0;
    for (int k = 0; k < lq.size(); k++) begin
      longint ps = 0;
      longint rs = 0;
      for (int j = 0; j < 4; j++) begin
        logic [31:0] lw = lq[k];
        logic [31:0] rw = rq[k];
        int x = $signed(lw[8*j +: 8]);
        int y = $signed(rw[8*j +: 8]);
        ps += x * y;
        rs += y;
      end
      a = fold(a + ps);
      r = fold(r + rs);
    end
    er = a;
    erow = r;
  endtask

  // Runs one job from the lq/rq queues. gap: 0 none, 1 alternate, 2 random.
  task automatic run_job(input int n, input int gap, input string tag);
    int idx = 0;
    int cyc = 0;
    int budget = 3 * n + 20;
    int hs0;
    bit v;
    bit rdy;
    start = 1'b1;
    num_words = 16'(n);
    tick();
    start = 1'b0;
    num_words = 16'(n + 3);
    hs0 = hs_count;
    if (n == 0) chk({tag, "_zero_in_ready"}, in_ready, 0);
    while (idx < n && cyc < budget) begin
      case (gap)
        1: v = (cyc % 2) == 0;
        2: v = $urandom_range(0, 1) == 1;
        default: v = 1'b1;
      endcase
      in_valid = v;
      lhs_data = lq[idx];
      rhs_data = rq[idx];
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      #1;
      cyc++;
      if (idx == n) chk({tag, "_latency_out_valid"}, out_valid, 1);
    end
    if (idx < n) chk({tag, "_timeout_beats"}, idx, n);
    in_valid = 1'b1;
    lhs_data = $urandom;
    rhs_data = $urandom;
    tick();
    in_valid = 1'b0;
    chk({tag, "_handshakes"}, hs_count - hs0, n);
    chk({tag, "_out_valid"}, out_valid, 1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, out_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_model(input string tag);
    longint er, erow;
    model(er, erow);
    chk({tag, "_res"}, $signed(res_out), er);
    chk({tag, "_row"}, $signed(row_sum_out), erow);
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] sat_exp;
    longint hold_res, hold_row;

    tbl[0] = '{32'h01020304, 32'h01010101, 10, 4};
    tbl[1] = '{32'h80808080, 32'h7F7F7F7F, -65024, 508};
    tbl[2] = '{32'h80808080, 32'h80808080, 65536, -512};
    tbl[3] = '{32'hFFFFFFFF, 32'h01020304, -10, 10};
    tbl[4] = '{32'h00000000, 32'hFFFFFFFF, 0, -4};
    tbl[5] = '{32'h7F000001, 32'h7F0000FF, 16128, 126};

    rst_n = 1'b0; start = 1'b0; num_words = '0; in_valid = 1'b0;
    lhs_data = '0; rhs_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_res", res_out, 0);
    chk("reset_row", row_sum_out, 0);
    rst_n = 1'b1;
    tick();

    // Single-beat table
    for (int t = 0; t < 6; t++) begin
      string tag = $sformatf("vec%0d", t);
      lq.delete(); rq.delete();
      lq.push_back(tbl[t].lhs); rq.push_back(tbl[t].rhs);
      run_job(1, 0, tag);
      chk({tag, "_res"}, $signed(res_out), tbl[t].exp_res);
      chk({tag, "_row"}, $signed(row_sum_out), tbl[t].exp_row);
      release_result(tag);
    end

    // Gapped three-beat job
    lq.delete(); rq.delete();
    repeat (3) begin lq.push_back(32'h80808080); rq.push_back(32'h7F7F7F7F); end
    run_job(3, 1, "gap3");
    chk("gap3_res", $signed(res_out), -195072);
    chk("gap3_row", $signed(row_sum_out), 1524);
    chk("gap3_in_ready_done", in_ready, 0);
    release_result("gap3");

    // Zero-length job
    lq.delete(); rq.delete();
    run_job(0, 0, "zero");
    chk("zero_res", res_out, 0);
    chk("zero_row", row_sum_out, 0);
    release_result("zero");

    // DONE hold with back-pressure, starts during DONE ignored
    lq.delete(); rq.delete();
    repeat (2) begin lq.push_back($urandom); rq.push_back($urandom); end
    run_job(2, 0, "hold");
    model(hold_res, hold_row);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      num_words = 16'd7;
      tick();
      start = 1'b0;
      chk($sformatf("hold_c%0d_out_valid", c), out_valid, 1);
      chk($sformatf("hold_c%0d_res", c), $signed(res_out), hold_res);
      chk($sformatf("hold_c%0d_row", c), $signed(row_sum_out), hold_row);
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("hold_release_out_valid", out_valid, 0);
    chk("hold_release_busy", busy, 0);
    chk("hold_release_res", $signed(res_out), hold_res);
    tick();
    chk("hold_coincident_start_ignored", busy, 0);

    // Reset mid-accumulation
    lq.delete(); rq.delete();
    start = 1'b1; num_words = 16'd4;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; lhs_data = 32'h11223344; rhs_data = 32'h05060708;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_res", res_out, 0);
    chk("rst_mid_row", row_sum_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    tick();
    #3 rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("rst_after_out_valid", out_valid, 0);
    end
    lq.push_back(32'h0102FF80); rq.push_back(32'h7F030201);
    run_job(1, 0, "rst_new");
    check_model("rst_new");
    release_result("rst_new");

    // Randomized jobs against the reference model
    for (int j = 0; j < 25; j++) begin
      string tag = $sformatf("rnd%0d", j);
      int n = $urandom_range(0, 6);
      lq.delete(); rq.delete();
      for (int k = 0; k < n; k++) begin lq.push_back($urandom); rq.push_back($urandom); end
      run_job(n, $urandom_range(0, 2), tag);
      check_model(tag);
      release_result(tag);
    end

    // Overflow: reach 0x7FFFFFF0, then one beat of +64
    lq.delete(); rq.delete();
    repeat (32767) begin lq.push_back(32'h80808080); rq.push_back(32'h80808080); end
    lq.push_back(32'h00808080); rq.push_back(32'h00808080);
    lq.push_back(32'h0000F080); rq.push_back(32'h00000180);
    lq.push_back(32'h00000008); rq.push_back(32'h00000008);
    run_job(32770, 0, "ovf");
`ifdef DOT_ACC_SATURATE_EN
    sat_exp = 32'h7FFFFFFF;
`else
    sat_exp = 32'h80000030;
`endif
    chk("ovf_res_const", res_out, sat_exp);
    check_model("ovf");
    release_result("ovf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
